// File: rtl/tank_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tank_cmd_scheduler
// Description : Captures per-player move/shoot commands into one pending slot
//               each, round-robin offers them to the shared tank engine over a
//               valid/ready handshake, and enforces a per-player shot cooldown.
//               Optional drop counters: define TANK_SCHED_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tank_cmd_scheduler #(
    parameter int COOL_W   = 16,
    parameter int COOLDOWN = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] p0_direct,
    input  logic       p0_moving,
    input  logic       p0_shoot,
    input  logic [2:0] p1_direct,
    input  logic       p1_moving,
    input  logic       p1_shoot,
    input  logic       eng_ready,
    output logic       eng_valid,
    output logic       eng_player,
    output logic [1:0] eng_op,
    output logic [2:0] eng_direct,
    output logic       p0_cool,
    output logic       p1_cool
`ifdef TANK_SCHED_DROP_CNT_EN
    ,
    output logic [7:0] p0_drops,
    output logic [7:0] p1_drops
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    localparam logic [2:0]        C_DIR_UP    = 3'b010;
    localparam logic [1:0]        C_OP_MOVE   = 2'b00;
    localparam logic [1:0]        C_OP_SHOOT  = 2'b01;
    localparam logic [COOL_W-1:0] C_COOL_LOAD = COOL_W'(COOLDOWN);
    localparam logic [COOL_W-1:0] C_COOL_ONE  = COOL_W'(1);

    state_e            state_q, state_d;
    logic              eng_valid_q, eng_valid_d;
    logic              eng_player_q, eng_player_d;
    logic [1:0]        eng_op_q, eng_op_d;
    logic [2:0]        eng_direct_q, eng_direct_d;
    logic              rr_q, rr_d;
    logic [1:0]        slot_full_q, slot_full_d;
    logic [1:0]        slot_shoot_q, slot_shoot_d;
    logic [2:0]        slot_dir_q [2];
    logic [2:0]        slot_dir_d [2];
    logic [2:0]        last_dir_q [2];
    logic [2:0]        last_dir_d [2];
    logic [COOL_W-1:0] cool_q [2];
    logic [COOL_W-1:0] cool_d [2];

    logic [2:0] in_dir [2];
    logic [1:0] in_moving;
    logic [1:0] in_shoot;

    assign in_dir[0]    = p0_direct;
    assign in_dir[1]    = p1_direct;
    assign in_moving    = {p1_moving, p0_moving};
    assign in_shoot     = {p1_shoot, p0_shoot};

    logic       handshake;
    logic       sel;
    logic [1:0] clear;
    logic [1:0] slot_free;
    logic [1:0] want_shoot;
    logic [1:0] want_move;
    logic [1:0] take_shoot;
    logic [1:0] take_move;

    assign handshake = (state_q == ST_OFFER) && eng_ready;
    assign sel       = slot_full_q[rr_q] ? rr_q : ~rr_q;

    // A slot released by this edge's handshake counts as free for refill.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_player
            assign clear[p]      = handshake && (eng_player_q == 1'(p));
            assign slot_free[p]  = !slot_full_q[p] || clear[p];
            assign want_shoot[p] = in_shoot[p] && !in_dir[p][2];
            assign want_move[p]  = in_moving[p] && !in_dir[p][2];
            assign take_shoot[p] = want_shoot[p] && slot_free[p] && (cool_q[p] == '0);
            assign take_move[p]  = want_move[p] && slot_free[p] && !take_shoot[p];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        eng_valid_d  = eng_valid_q;
        eng_player_d = eng_player_q;
        eng_op_d     = eng_op_q;
        eng_direct_d = eng_direct_q;
        rr_d         = rr_q;
        slot_full_d  = slot_full_q;
        slot_shoot_d = slot_shoot_q;
        for (int p = 0; p < 2; p++) begin
            slot_dir_d[p] = slot_dir_q[p];
            last_dir_d[p] = last_dir_q[p];
            cool_d[p]     = cool_q[p];
            if (clear[p]) begin
                slot_full_d[p] = 1'b0;
            end
            if (take_shoot[p]) begin
                slot_full_d[p]  = 1'b1;
                slot_shoot_d[p] = 1'b1;
                slot_dir_d[p]   = last_dir_q[p];
            end else if (take_move[p]) begin
                slot_full_d[p]  = 1'b1;
                slot_shoot_d[p] = 1'b0;
                slot_dir_d[p]   = in_dir[p];
            end
            if (want_move[p]) begin
                last_dir_d[p] = in_dir[p];
            end
            // Cooldown starts when the engine takes the shot, not at capture.
            if (clear[p] && slot_shoot_q[p]) begin
                cool_d[p] = C_COOL_LOAD;
            end else if (cool_q[p] != '0) begin
                cool_d[p] = cool_q[p] - C_COOL_ONE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|slot_full_q) begin
                    eng_player_d = sel;
                    eng_op_d     = slot_shoot_q[sel] ? C_OP_SHOOT : C_OP_MOVE;
                    eng_direct_d = slot_dir_q[sel];
                    eng_valid_d  = 1'b1;
                    state_d      = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (eng_ready) begin
                    eng_valid_d = 1'b0;
                    rr_d        = ~eng_player_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            eng_valid_q  <= 1'b0;
            eng_player_q <= 1'b0;
            eng_op_q     <= C_OP_MOVE;
            eng_direct_q <= C_DIR_UP;
            rr_q         <= 1'b0;
            slot_full_q  <= '0;
            slot_shoot_q <= '0;
            for (int p = 0; p < 2; p++) begin
                slot_dir_q[p] <= C_DIR_UP;
                last_dir_q[p] <= C_DIR_UP;
                cool_q[p]     <= '0;
            end
        end else begin
            state_q      <= state_d;
            eng_valid_q  <= eng_valid_d;
            eng_player_q <= eng_player_d;
            eng_op_q     <= eng_op_d;
            eng_direct_q <= eng_direct_d;
            rr_q         <= rr_d;
            slot_full_q  <= slot_full_d;
            slot_shoot_q <= slot_shoot_d;
            for (int p = 0; p < 2; p++) begin
                slot_dir_q[p] <= slot_dir_d[p];
                last_dir_q[p] <= last_dir_d[p];
                cool_q[p]     <= cool_d[p];
            end
        end
    end

    assign eng_valid  = eng_valid_q;
    assign eng_player = eng_player_q;
    assign eng_op     = eng_op_q;
    assign eng_direct = eng_direct_q;
    assign p0_cool    = (cool_q[0] != '0);
    assign p1_cool    = (cool_q[1] != '0);

`ifdef TANK_SCHED_DROP_CNT_EN
    logic [1:0] drop_evt;
    logic [7:0] drops_q [2];
    logic [7:0] drops_d [2];

    // A move that loses to a same-cycle shot is not a drop.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_drop
            assign drop_evt[p] = (want_shoot[p] && (!slot_free[p] || (cool_q[p] != '0)))
                               || (want_move[p] && !slot_free[p]);
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            drops_d[p] = drops_q[p];
            if (drop_evt[p] && (drops_q[p] != 8'hFF)) begin
                drops_d[p] = drops_q[p] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                drops_q[p] <= 8'd0;
            end else begin
                drops_q[p] <= drops_d[p];
            end
        end
    end

    assign p0_drops = drops_q[0];
    assign p1_drops = drops_q[1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_tank_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_cmd_scheduler
// Description : Directed scenarios plus random traffic for tank_cmd_scheduler,
//               checked against a command-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_cmd_scheduler;

    localparam int COOLDOWN = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] p0_direct, p1_direct;
    logic       p0_moving, p0_shoot, p1_moving, p1_shoot;
    logic       eng_ready;
    logic       eng_valid, eng_player;
    logic [1:0] eng_op;
    logic [2:0] eng_direct;
    logic       p0_cool, p1_cool;
`ifdef TANK_SCHED_DROP_CNT_EN
    logic [7:0] p0_drops, p1_drops;
`endif

    always #5 clk = ~clk;

    tank_cmd_scheduler #(
        .COOL_W   (16),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p0_direct  (p0_direct),
        .p0_moving  (p0_moving),
        .p0_shoot   (p0_shoot),
        .p1_direct  (p1_direct),
        .p1_moving  (p1_moving),
        .p1_shoot   (p1_shoot),
        .eng_ready  (eng_ready),
        .eng_valid  (eng_valid),
        .eng_player (eng_player),
        .eng_op     (eng_op),
        .eng_direct (eng_direct),
        .p0_cool    (p0_cool),
        .p1_cool    (p1_cool)
`ifdef TANK_SCHED_DROP_CNT_EN
        ,
        .p0_drops   (p0_drops),
        .p1_drops   (p1_drops)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one pending command per player, an "offer" record for
    // the engine, and integer cooldown/drop counts.
    int m_full  [2];
    int m_shoot [2];
    int m_dir   [2];
    int m_last  [2];
    int m_cool  [2];
    int m_drops [2];
    int m_valid, m_player, m_op, m_edir, m_rr;

    task automatic model_step();
        int dir [2];
        int mv  [2];
        int sh  [2];
        int hs, e_valid, e_player, e_op, e_edir, e_rr, pick;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                m_full[p] = 0; m_shoot[p] = 0; m_dir[p] = 2;
                m_last[p] = 2; m_cool[p] = 0; m_drops[p] = 0;
            end
            m_valid = 0; m_player = 0; m_op = 0; m_edir = 2; m_rr = 0;
            return;
        end
        dir[0] = int'(p0_direct); mv[0] = int'(p0_moving); sh[0] = int'(p0_shoot);
        dir[1] = int'(p1_direct); mv[1] = int'(p1_moving); sh[1] = int'(p1_shoot);
        hs = (m_valid == 1 && eng_ready) ? 1 : 0;

        e_valid = m_valid; e_player = m_player; e_op = m_op; e_edir = m_edir; e_rr = m_rr;
        if (hs == 1) begin
            e_valid = 0;
            e_rr    = 1 - m_player;
        end else if (m_valid == 0 && (m_full[0] == 1 || m_full[1] == 1)) begin
            pick     = (m_full[m_rr] == 1) ? m_rr : 1 - m_rr;
            e_valid  = 1;
            e_player = pick;
            e_op     = m_shoot[pick];
            e_edir   = m_dir[pick];
        end

        for (int p = 0; p < 2; p++) begin
            int released, busy, ok, old_cool, dropped;
            released = (hs == 1 && m_player == p) ? 1 : 0;
            busy     = (m_full[p] == 1 && released == 0) ? 1 : 0;
            ok       = (dir[p] < 4) ? 1 : 0;
            old_cool = m_cool[p];
            dropped  = 0;
            if (released == 1) m_full[p] = 0;
            if (released == 1 && m_shoot[p] == 1) m_cool[p] = COOLDOWN;
            else if (m_cool[p] > 0)               m_cool[p] = m_cool[p] - 1;
            if (sh[p] == 1 && ok == 1 && busy == 0 && old_cool == 0) begin
                m_full[p] = 1; m_shoot[p] = 1; m_dir[p] = m_last[p];
            end else begin
                if (sh[p] == 1 && ok == 1) dropped = 1;
                if (mv[p] == 1 && ok == 1) begin
                    if (busy == 0) begin
                        m_full[p] = 1; m_shoot[p] = 0; m_dir[p] = dir[p];
                    end else begin
                        dropped = 1;
                    end
                end
            end
            if (dropped == 1 && m_drops[p] < 255) m_drops[p] = m_drops[p] + 1;
            if (mv[p] == 1 && ok == 1) m_last[p] = dir[p];
        end

        m_valid = e_valid; m_player = e_player; m_op = e_op; m_edir = e_edir; m_rr = e_rr;
    endtask

    task automatic compare_model();
        chk_val("m_valid",  eng_valid,  m_valid);
        chk_val("m_player", eng_player, m_player);
        chk_val("m_op",     eng_op,     m_op);
        chk_val("m_direct", eng_direct, m_edir);
        chk_val("m_p0cool", p0_cool,    (m_cool[0] != 0) ? 1 : 0);
        chk_val("m_p1cool", p1_cool,    (m_cool[1] != 0) ? 1 : 0);
`ifdef TANK_SCHED_DROP_CNT_EN
        chk_val("m_p0drops", p0_drops,  m_drops[0]);
        chk_val("m_p1drops", p1_drops,  m_drops[1]);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        p0_direct = 3'b010; p0_moving = 1'b0; p0_shoot = 1'b0;
        p1_direct = 3'b010; p1_moving = 1'b0; p1_shoot = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        eng_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] rnd_dir();
        if ($urandom_range(0, 4) == 0) return 3'(4 + $urandom_range(0, 3));
        return 3'($urandom_range(0, 3));
    endfunction

    initial begin
        int exp_p;
        rst = 1'b1;
        idle_inputs();
        eng_ready = 1'b1;

        // Reset held 2 cycles with stimulus active
        p0_moving = 1'b1; p0_direct = 3'b001; p1_shoot = 1'b1; p1_direct = 3'b000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_val("rst_valid",  eng_valid,  0);
            chk_val("rst_direct", eng_direct, 3'b010);
            chk_val("rst_p0cool", p0_cool,    0);
            chk_val("rst_p1cool", p1_cool,    0);
        end
        rst = 1'b0;
        tick();
        chk_val("rst_first_edge_valid", eng_valid, 0);
        idle_inputs();
        repeat (12) tick();

        // Single move
        do_reset();
        eng_ready = 1'b1;
        p0_moving = 1'b1; p0_direct = 3'b001;
        tick();
        chk_val("mv_lat1_valid", eng_valid, 0);
        idle_inputs();
        tick();
        chk_val("mv_valid",  eng_valid,  1);
        chk_val("mv_player", eng_player, 0);
        chk_val("mv_op",     eng_op,     2'b00);
        chk_val("mv_direct", eng_direct, 3'b001);
        tick();
        chk_val("mv_held1", eng_valid, 0);

        // Shoot plus cooldown
        do_reset();
        eng_ready = 1'b1;
        p1_moving = 1'b1; p1_direct = 3'b011;
        tick();
        p1_moving = 1'b0;
        tick();
        chk_val("sh_move_valid", eng_valid, 1);
        p1_shoot = 1'b1;
        tick();
        p1_shoot = 1'b0;
        tick();
        chk_val("sh_valid",  eng_valid,  1);
        chk_val("sh_player", eng_player, 1);
        chk_val("sh_op",     eng_op,     2'b01);
        chk_val("sh_direct", eng_direct, 3'b011);
        tick();
        chk_val("cool_c1", p1_cool, 1);
        tick();
        chk_val("cool_c2", p1_cool, 1);
        p1_shoot = 1'b1;
        tick();
        p1_shoot = 1'b0;
        chk_val("cool_c3", p1_cool, 1);
        tick();
        chk_val("cool_c4", p1_cool, 1);
        tick();
        chk_val("cool_c5", p1_cool, 1);
        tick();
        chk_val("cool_done", p1_cool, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_val("cool_no_issue", eng_valid, 0);
        end

        // Arbitration: both players pressing every cycle
        do_reset();
        eng_ready = 1'b1;
        p0_moving = 1'b1; p1_moving = 1'b1;
        exp_p = 0;
        for (int k = 1; k <= 12; k++) begin
            p0_direct = 3'($urandom_range(0, 3));
            p1_direct = 3'($urandom_range(0, 3));
            tick();
            if (k >= 2) begin
                chk_val("arb_valid", eng_valid, (k % 2 == 0) ? 1 : 0);
                if (k % 2 == 0) begin
                    chk_val("arb_player", eng_player, exp_p);
                    exp_p = 1 - exp_p;
                end
            end
        end

        // Backpressure
        do_reset();
        p0_moving = 1'b1; p0_direct = 3'b000;
        tick();
        idle_inputs();
        tick();
        chk_val("bp_offer", eng_valid, 1);
        p0_moving = 1'b1; p0_direct = 3'b001; p0_shoot = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_val("bp_valid",  eng_valid,  1);
            chk_val("bp_player", eng_player, 0);
            chk_val("bp_op",     eng_op,     2'b00);
            chk_val("bp_direct", eng_direct, 3'b000);
        end
`ifdef TANK_SCHED_DROP_CNT_EN
        chk_val("bp_drops", p0_drops, 10);
`endif
        idle_inputs();
        eng_ready = 1'b1;
        tick();
        chk_val("bp_release", eng_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_val("bp_no_reissue", eng_valid, 0);
        end

        // Mid-offer reset
        do_reset();
        p0_moving = 1'b1; p0_direct = 3'b010;
        tick();
        idle_inputs();
        tick();
        chk_val("mr_offer", eng_valid, 1);
        rst = 1'b1;
        tick();
        chk_val("mr_cleared", eng_valid, 0);
        rst = 1'b0;
        eng_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_val("mr_no_reoffer", eng_valid, 0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            p0_direct = rnd_dir();
            p1_direct = rnd_dir();
            p0_moving = ($urandom_range(0, 1) == 0);
            p1_moving = ($urandom_range(0, 1) == 0);
            p0_shoot  = ($urandom_range(0, 3) == 0);
            p1_shoot  = ($urandom_range(0, 3) == 0);
            eng_ready = ($urandom_range(0, 4) < 3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tank_cmd_scheduler.md
Name: tank_cmd_scheduler

Overview:
- Shares one tank motion/bullet engine between two players.
- Each player has a keyboard-direction decoder producing per-cycle direct/moving/shoot levels. This block captures those as pending commands, one slot per player.
- It round-robin arbitrates between the two slots and offers one command at a time to the engine over a valid/ready handshake.
- It enforces a per-player shot cooldown. Sits between the two decoders and the game-logic engine.

Parameters:
- COOL_W, 16, width of each cooldown counter.
- COOLDOWN, 1000, cycles a player is barred from shooting after one of its shoot commands is accepted. Must be ≥1 and < 2^COOL_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_direct  in  3  player 0 direction: 000 L, 001 R, 010 U, 011 D.
- p0_moving  in  1  player 0 move request level.
- p0_shoot  in  1  player 0 shoot request level.
- p1_direct  in  3  player 1 direction.
- p1_moving  in  1  player 1 move request.
- p1_shoot  in  1  player 1 shoot request.
- eng_ready  in  1  engine accepts the offered command this cycle.
- eng_valid  out  1  command offered.
- eng_player  out  1  issuing player (0/1).
- eng_op  out  2  00 move, 01 shoot; 10/11 never driven.
- eng_direct  out  3  direction for the command.
- p0_cool  out  1  player 0 cooldown counter nonzero.
- p1_cool  out  1  player 1 cooldown counter nonzero.

Behaviour:
- Reset values (next edge with rst=1):
  - eng_valid=0, eng_player=0, eng_op=00, eng_direct=010.
  - Both slots empty, both cooldowns 0 (p0_cool=p1_cool=0), both last_dir=010 (UP).
  - rr pointer=0, FSM=IDLE.
  - rst overrides everything, including an in-flight offer. The command is discarded and never re-offered.
- Per player X, each edge:
  - last_dir: if pX_moving=1 and pX_direct[2]=0, last_dir<=pX_direct.
  - A move or shoot with pX_direct[2]=1 is ignored.
  - Shoot capture: pX_shoot=1, slot free, cooldown=0 → slot<={shoot, last_dir value before this edge}.
  - Move capture: otherwise, pX_moving=1 with valid dir, slot free → slot<={move, pX_direct}.
  - Shoot wins over move in the same cycle. A move loses only if it competes for a free slot.
  - "Slot free" includes the slot being cleared by a handshake on this same edge. Clear and refill happen on the same edge, and the new command is kept.
  - Events arriving while the slot is held are dropped.
  - A shoot during cooldown is dropped, even if the slot is free.
- Cooldown:
  - Counter decrements by 1 per cycle while nonzero; it saturates at 0.
  - Loaded with COOLDOWN on the edge a shoot from that player is accepted. The load overrides the decrement.
  - pX_cool = (counter != 0), combinational from the register.
- FSM IDLE:
  - If any slot is full, select the player: rr if slot[rr] is full, else the other.
  - Register payload into eng_*, set eng_valid=1, go OFFER.
  - Capture-to-offer latency: input at edge t → slot full after t → eng_valid=1 after t+1.
- FSM OFFER:
  - eng_valid and payload stay stable until eng_ready=1.
  - On handshake edge: clear that slot, rr<=~eng_player, eng_valid<=0, go IDLE.
  - Throughput is at most one command per 2 cycles (one bubble).
  - eng_ready while eng_valid=0 is ignored.
- Fairness: with both slots continuously refilled, issues alternate P0, P1, P0...
- Both players idle: FSM stays in IDLE, eng_valid=0, and payload outputs hold their last values.

Optional Feature:
- Macro: TANK_SCHED_DROP_CNT_EN.
- When defined:
  - Adds outputs p0_drops and p1_drops, 8 bits each.
  - Each counts one per cycle in which that player's valid event (move or shoot) was discarded because the slot was held or cooldown was active.
  - Counters saturate at 255 and are reset to 0 by rst.
- When undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with stimulus active → eng_valid=0, eng_direct=010, p0_cool=p1_cool=0, and eng_valid=0 on the first edge after rst drops.
- Single move: p0_moving=1, p0_direct=001 for one cycle, eng_ready=1 → eng_valid=1 exactly 2 edges later with player 0, op 00, direct 001, held for 1 cycle.
- Shoot plus cooldown (COOLDOWN=5):
  - P1 moves 011, then p1_shoot pulse → shoot offered with direct 011. p1_cool=1 for exactly 5 cycles after the handshake.
  - A p1_shoot pulse 2 cycles after the handshake → no command issued.
- Arbitration: p0 and p1 both press moves every cycle, eng_ready=1 → issues alternate player 0,1,0,1, each eng_valid pulse separated by one idle cycle.
- Backpressure: eng_ready=0 for 10 cycles with an offer pending → payload stable. P0 inputs during the stall are dropped (drop counter +1 per cycle with TANK_SCHED_DROP_CNT_EN). Raising eng_ready issues only the original command.
- Mid-offer reset: rst=1 while eng_valid=1 and eng_ready=0 → eng_valid=0 next edge, slots empty, and the command is not re-offered after reset.
